osc_gate_counter: RTL

Measures ring-oscillator frequency: counts rising edges of an asynchronous oscillator signal over a fixed window of GATE_CYCLES clk cycles and delivers one WIDTH-bit count per window over a valid/ready handshake.
Sits directly upstream of the averaging stage, which consumes count_out/count_valid. Replaces free-running counting with deterministic gated sampling.

---
 rtl/osc_gate_counter_pkg.sv | 27 ++
 rtl/osc_gate_counter_if.sv | 19 +
 rtl/osc_gate_counter_sync_edge_detect.sv | 33 +++
 rtl/osc_gate_counter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/osc_gate_counter_pkg.sv
// Shared definitions for the oscillator gate counter.
// Holds the state encoding used by the gating FSM and a saturating
// increment helper that works on 32-bit values so any counter up to
// 32 bits wide can share it.
package osc_gate_counter_pkg;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_GATE = 2'd1;
    localparam logic [1:0] STATE_HOLD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = STATE_IDLE,
        GATE = STATE_GATE,
        HOLD = STATE_HOLD
    } state_t;

    // Adds inc to value unless value already sits at max_value.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic        inc,
                                            input logic [31:0] max_value);
        if (inc && (value != max_value)) begin
            return value + 32'd1;
        end
        return value;
    endfunction

endpackage

// File: rtl/osc_gate_counter_if.sv
// Result handshake between the gate counter and the averaging stage.
//   count_out   : measured edge count
//   count_valid : result available, held until accepted
//   count_ready : consumer takes the result when high with count_valid
//   overflow    : result saturated, travels with count_out
// master = producer (gate counter), slave = consumer.
interface osc_gate_counter_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] count_out;
    logic             count_valid;
    logic             count_ready;
    logic             overflow;

    modport master (output count_out, output count_valid, output overflow,
                    input count_ready);
    modport slave  (input count_out, input count_valid, input overflow,
                    output count_ready);
endinterface

// File: rtl/osc_gate_counter_sync_edge_detect.sv
// Synchronizer chain plus rising-edge pulse for an asynchronous input.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   din   : asynchronous input pin
//   rise  : one-cycle pulse when the synchronized level goes 0 -> 1
// The pulse is combinational from the last two flops, so a pin change
// is reflected in registered logic downstream SYNC_STAGES+1 edges later.
// Inputs faster than half the clock rate alias silently.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);
    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign rise = chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/osc_gate_counter.sv
// Ring-oscillator frequency measurement by gated edge counting.
// Counts rising edges of osc_in over exactly GATE_CYCLES clk cycles and
// hands one WIDTH-bit result per window to the consumer.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   osc_in      : oscillator output, asynchronous to clk
//   en          : block enable, low aborts a running window
//   start       : single-shot request, sampled while idle
//   continuous  : restart a window after each accepted result
//   busy        : high whenever the FSM is not idle
//   result      : count_out/count_valid/count_ready/overflow handshake
module osc_gate_counter
    import osc_gate_counter_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int GATE_CYCLES = 10000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                osc_in,
    input  logic                en,
    input  logic                start,
    input  logic                continuous,
    output logic                busy,
    osc_gate_counter_if.master  result
);
    localparam int          GATE_W   = $clog2(GATE_CYCLES);
    localparam logic [31:0] MAX_WIDE = 32'((64'd1 << WIDTH) - 64'd1);

    state_t              state;
    state_t              state_next;
    logic [GATE_W-1:0]   gate_cnt;
    logic [WIDTH-1:0]    edge_cnt;
    logic [WIDTH-1:0]    edge_next;
    logic                ovf_int;
    logic                rise;
    logic                at_max;
    logic                last_cycle;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (osc_in),
        .rise (rise)
    );

    assign at_max     = (32'(edge_cnt) == MAX_WIDE);
    assign edge_next  = WIDTH'(sat_inc(32'(edge_cnt), rise, MAX_WIDE));
    assign last_cycle = (gate_cnt == GATE_W'(GATE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Disabling during a window abandons it; a pending result is always
    // delivered, and only re-arms when still enabled and continuous.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (en && (start || continuous)) begin
                    state_next = GATE;
                end
            end
            GATE: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (last_cycle) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (result.count_ready) begin
                    state_next = (en && continuous) ? GATE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy               = (state != IDLE);
    assign result.count_valid = (state == HOLD);

    // Counters only run in GATE and are held clear otherwise, so every
    // window starts from zero. The result registers are written only at
    // the end of a complete window and otherwise keep the last result;
    // the final cycle's rise is folded in via edge_next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt         <= '0;
            edge_cnt         <= '0;
            ovf_int          <= 1'b0;
            result.count_out <= '0;
            result.overflow  <= 1'b0;
        end else if (state == GATE) begin
            if (en) begin
                gate_cnt <= gate_cnt + 1'b1;
                edge_cnt <= edge_next;
                if (rise && at_max) begin
                    ovf_int <= 1'b1;
                end
                if (last_cycle) begin
                    result.count_out <= edge_next;
                    result.overflow  <= ovf_int | (rise & at_max);
                end
            end
        end else begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_int  <= 1'b0;
        end
    end

endmodule
